// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic blocks: digit type, correction constants and
// the serial-adder state encoding.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_CORR = 4'd6;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal correction; digits above 9 are
// processed with the same rule and the result is truncated to 4 bits.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] digit_o,
    output logic       cout_o
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
        if (t > {1'b0, BCD_MAX}) begin
            digit_o = t[3:0] + BCD_CORR;
            cout_o  = 1'b1;
        end else begin
            digit_o = t[3:0];
            cout_o  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, one digit per clock, LSD first.
// Define BCD_SERIAL_ADDER_CHECK_EN to enable the sticky invalid-digit flag on err.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d;

    digit_t a_dig, b_dig, sum_dig;
    logic   carry_nxt;
    logic   accept;

    assign a_dig  = a_q[idx_q*DIGIT_W +: DIGIT_W];
    assign b_dig  = b_q[idx_q*DIGIT_W +: DIGIT_W];
    assign accept = start && (state_q != RUN);

    bcd_digit_adder u_digit (
        .a_i     (a_dig),
        .b_i     (b_dig),
        .cin_i   (carry_q),
        .digit_o (sum_dig),
        .cout_o  (carry_nxt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[idx_q*DIGIT_W +: DIGIT_W] = sum_dig;
                carry_d = carry_nxt;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = carry_nxt;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef BCD_SERIAL_ADDER_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (state_q == RUN && (a_dig > BCD_MAX || b_dig > BCD_MAX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: stimulus pushes expected results, a monitor checks
// each done pulse against them (sum, cout, err, latency, busy length).
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_run = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           t0;
    } exp_t;

    exp_t sb[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value arithmetic for valid operands; digit rule for non-BCD digits.
    function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
        exp_t   e;
        longint va = 0, vb = 0, p = 1, tot;
        bit     ok = 1;
        int     cr, t, da, db;
        e.sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) ok = 0;
            va += da * p;
            vb += db * p;
            p  *= 10;
        end
        if (ok) begin
            tot    = va + vb + longint'(c);
            e.cout = (tot >= p);
            tot    = tot % p;
            for (int i = 0; i < DIGITS; i++) begin
                e.sum[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            cr = int'(c);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cr;
                if (t > 9) begin
                    e.sum[4*i +: 4] = 4'((t + 6) % 16);
                    cr = 1;
                end else begin
                    e.sum[4*i +: 4] = 4'(t);
                    cr = 0;
                end
            end
            e.cout = cr[0];
        end
`ifdef BCD_SERIAL_ADDER_CHECK_EN
        e.err = !ok;
`else
        e.err = 1'b0;
`endif
        e.t0 = 0;
        return e;
    endfunction

    // Issue one op at a negedge; hold keeps start high that many extra cycles with junk operands.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int hold);
        exp_t e;
        int   n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("busy_timeout", 1, 0);
        e     = ref_add(a, b, c);
        e.t0  = cyc + 1;
        sb.push_back(e);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            cin_in = ~cin_in;
            @(negedge clk);
        end
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", done, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && ($urandom_range(0, 7) == 0)) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                    chk("err", err, e.err);
                    chk("latency", cyc - e.t0, DIGITS);
                    chk("busy_len", busy_run, DIGITS);
                end
            end
            if (!busy && !done) busy_run = 0;
            if (done) busy_run = 0;
        end
`ifndef BCD_SERIAL_ADDER_CHECK_EN
        if (err) chk("err_tied_low", err, 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h1234, 16'h5678, 1'b0, 0);
        drain();
        do_op(16'h9999, 16'h0001, 1'b0, 0);
        drain();
        do_op(16'h0000, 16'h0000, 1'b1, 0);
        drain();

        // start held through RUN while operands wander
        do_op(16'h2468, 16'h1357, 1'b1, 3);
        drain();

        // back-to-back: second start lands in the DONE cycle
        do_op(16'h1111, 16'h2222, 1'b0, 0);
        wait_done();
        do_op(16'h0500, 16'h0500, 1'b0, 0);
        drain();

        // reset mid-RUN with index=2
        do_op(16'h8765, 16'h4321, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'h4999, 16'h0001, 1'b0, 0);
        drain();

        // invalid digit, then a valid op that must clear err
        do_op(16'h12A4, 16'h0000, 1'b0, 0);
        drain();
        do_op(16'h0042, 16'h0058, 1'b0, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            do_op(rand_bcd(i % 4 == 3), rand_bcd(1'b0), 1'($urandom), 0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
